// File: rtl/branch_flag_unit_if.sv
// ============================================================================
// Module      : branch_flag_unit_if
// Description : Execute-stage to branch-flag bus; master drives EX/control,
//               slave (branch_flag_unit) returns flags and flags_pending.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_flag_unit_if #(
  parameter int DATA_W = 16
);
  logic              ex_valid;
  logic [4:0]        ex_opcode;
  logic [DATA_W-1:0] ex_result;
  logic              ex_ovf;
  logic              stall;
  logic              flush;
  logic              int_save;
  logic              int_restore;
  logic [1:0]        flags;
  logic              flags_pending;

  modport master (
    output ex_valid, ex_opcode, ex_result, ex_ovf,
    output stall, flush, int_save, int_restore,
    input  flags, flags_pending
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result, ex_ovf,
    input  stall, flush, int_save, int_restore,
    output flags, flags_pending
  );
endinterface

`default_nettype wire

// File: rtl/branch_flag_unit.sv
// ============================================================================
// Module      : branch_flag_unit
// Description : Registers Z/N condition flags from ALU results for branch
//               logic, with stall/flush and interrupt save/restore.
//               Optional macro FLAG_BYPASS_EN forwards S1 flags combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_flag_unit #(
  parameter int          DATA_W        = 16,
  parameter logic [31:0] FLAG_SET_MASK = 32'h0004_07FE
) (
  input  logic               clk,
  input  logic               rst,
  branch_flag_unit_if.slave  bus
);

  logic       w_set_ex;
  logic       r_s1_valid;
  logic       r_s1_z;
  logic       r_s1_n;
  logic [1:0] r_flags;
  logic [1:0] r_shadow;

  assign w_set_ex = bus.ex_valid & FLAG_SET_MASK[bus.ex_opcode];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_z     <= 1'b0;
      r_s1_n     <= 1'b0;
      r_flags    <= 2'b00;
      r_shadow   <= 2'b00;
    end else if (!bus.stall) begin
      r_s1_valid <= w_set_ex & ~bus.flush & ~bus.int_restore;
      r_s1_z     <= (bus.ex_result == '0);
      r_s1_n     <= bus.ex_result[DATA_W-1] ^ bus.ex_ovf;
      // Save samples the pre-edge flags, so save+restore together swaps.
      if (bus.int_save)
        r_shadow <= r_flags;
      if (bus.int_restore)
        r_flags <= r_shadow;
      else if (r_s1_valid)
        r_flags <= {r_s1_z, r_s1_n};
    end
  end

`ifdef FLAG_BYPASS_EN
  assign bus.flags         = (r_s1_valid & ~bus.stall) ? {r_s1_z, r_s1_n} : r_flags;
  assign bus.flags_pending = ~rst & w_set_ex;
`else
  assign bus.flags         = r_flags;
  assign bus.flags_pending = ~rst & (r_s1_valid | w_set_ex);
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_flag_unit.sv
// ============================================================================
// Module      : tb_branch_flag_unit
// Description : Scoreboard bench for branch_flag_unit (default build timing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_flag_unit;

  localparam logic [4:0] c_cmp = 5'b10010;
  localparam logic [4:0] c_beq = 5'b10011;

  typedef struct {
    logic [1:0] f;
    logic       p;
    int         id;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   vec_id;
  exp_t sb_q[$];

  branch_flag_unit_if #(.DATA_W(16)) bus ();

  branch_flag_unit #(
    .DATA_W        (16),
    .FLAG_SET_MASK (32'h0004_07FE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (bus.flags !== e.f) begin
        failures++;
        $display("FAIL vec%0d flags: got %b expected %b", e.id, bus.flags, e.f);
      end
      checks++;
      if (bus.flags_pending !== e.p) begin
        failures++;
        $display("FAIL vec%0d flags_pending: got %b expected %b", e.id, bus.flags_pending, e.p);
      end
    end
  end

  // Apply one cycle of inputs, queue the expected outputs, advance past the edge.
  task automatic cyc(input logic r, input logic v, input logic [4:0] op,
                     input logic [15:0] res, input logic ovf, input logic st,
                     input logic fl, input logic sv, input logic rs,
                     input logic [1:0] ef, input logic ep);
    exp_t e;
    rst             = r;
    bus.ex_valid    = v;
    bus.ex_opcode   = op;
    bus.ex_result   = res;
    bus.ex_ovf      = ovf;
    bus.stall       = st;
    bus.flush       = fl;
    bus.int_save    = sv;
    bus.int_restore = rs;
    e.f  = ef;
    e.p  = ep;
    e.id = vec_id;
    vec_id++;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] ef, input logic ep);
    cyc(1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ef, ep);
  endtask

  task automatic cmp(input logic [15:0] res, input logic ovf,
                     input logic [1:0] ef, input logic ep);
    cyc(1'b0, 1'b1, c_cmp, res, ovf, 1'b0, 1'b0, 1'b0, 1'b0, ef, ep);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vec_id   = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_opcode = 5'd0; bus.ex_result = 16'h0;
    bus.ex_ovf = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.int_save = 1'b0; bus.int_restore = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a live CMP
    repeat (3) cyc(1'b1, 1'b1, c_cmp, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // Basic CMP results, 2-edge latency
    cmp(16'h0000, 1'b0, 2'b00, 1'b1);
    idle(2'b00, 1'b1);
    idle(2'b10, 1'b0);
    cmp(16'h8001, 1'b0, 2'b10, 1'b1);
    idle(2'b10, 1'b1);
    // BEQ must not touch flags
    cyc(1'b0, 1'b1, c_beq, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    idle(2'b01, 1'b0);
    cmp(16'h8001, 1'b1, 2'b01, 1'b1);
    idle(2'b01, 1'b1);
    idle(2'b00, 1'b0);

    // Stall with Z=1 held in S1; a restore during stall is ignored
    cmp(16'h0000, 1'b0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    idle(2'b00, 1'b1);
    idle(2'b10, 1'b0);

    // Flushed CMP never commits
    cyc(1'b0, 1'b1, c_cmp, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    idle(2'b10, 1'b0);
    idle(2'b10, 1'b0);

    // Save 10, overwrite with 01, restore 10
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    cmp(16'h8001, 1'b0, 2'b10, 1'b1);
    idle(2'b10, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(2'b10, 1'b0);

    // Restore coinciding with an S1 commit: shadow wins
    cmp(16'h8001, 1'b1, 2'b10, 1'b1);
    idle(2'b10, 1'b1);
    cmp(16'h8001, 1'b0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    idle(2'b10, 1'b0);

    // Swap: flags 01, shadow 10
    cmp(16'h8001, 1'b0, 2'b10, 1'b1);
    idle(2'b10, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    idle(2'b10, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    idle(2'b01, 1'b0);

    // Reset mid-flight drops the S1 update
    cmp(16'h0000, 1'b0, 2'b01, 1'b1);
    cyc(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    idle(2'b00, 1'b0);
    idle(2'b00, 1'b0);

    // Back-to-back setting ops
    cmp(16'h0000, 1'b0, 2'b00, 1'b1);
    cmp(16'h8001, 1'b0, 2'b00, 1'b1);
    idle(2'b10, 1'b1);
    idle(2'b01, 1'b0);

    // ALU opcode 01010 sets flags, 01011 does not
    cyc(1'b0, 1'b1, 5'b01010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    cyc(1'b0, 1'b1, 5'b01011, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    idle(2'b10, 1'b0);
    idle(2'b10, 1'b0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
